q_transition_monitor: RTL and testbench

Downstream observation stage for the registered output `Q` of the gate-plus-flip-flop timing circuit. It samples `Q` once per clock and counts rising and falling transitions. It also records the shortest and longest completed run (consecutive cycles at one level) and flags a stuck output. A measurement window opens on `Start` and closes on `Stop`; results hold stable until the next `Start`.

---
 rtl/q_transition_monitor_if.sv | 27 ++
 rtl/q_transition_monitor.sv | 111 +++++++++++
 tb/tb_q_transition_monitor.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/q_transition_monitor_if.sv
// Signal bundle between the Q-observation stage and its driver/consumer.
// The monitor itself connects through the slave modport.
interface q_transition_monitor_if #(
    parameter int CNT_W = 16,
    parameter int RUN_W = 8
);
    logic             Q_in;
    logic             Start;
    logic             Stop;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Rise_Cnt;
    logic [CNT_W-1:0] Fall_Cnt;
    logic [RUN_W-1:0] Max_Run;
    logic [RUN_W-1:0] Min_Run;
    logic             Err_Stuck;

    modport master (
        output Q_in, Start, Stop,
        input  Busy, Done, Rise_Cnt, Fall_Cnt, Max_Run, Min_Run, Err_Stuck
    );

    modport slave (
        input  Q_in, Start, Stop,
        output Busy, Done, Rise_Cnt, Fall_Cnt, Max_Run, Min_Run, Err_Stuck
    );
endinterface

// File: rtl/q_transition_monitor.sv
// Samples Q once per clock inside a Start/Stop window; counts edges, tracks
// shortest/longest completed run and flags a run that reaches STUCK_LIMIT.
module q_transition_monitor #(
    parameter int CNT_W       = 16,
    parameter int RUN_W       = 8,
    parameter int STUCK_LIMIT = 200
) (
    input  logic                   Clk,
    input  logic                   Rst,
    q_transition_monitor_if.slave  mon
);
    localparam logic [RUN_W-1:0] LIMIT = RUN_W'(STUCK_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic             q_prev;
    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] run_inc;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] rise_r;
    logic [CNT_W-1:0] fall_r;
    logic [RUN_W-1:0] max_r;
    logic [RUN_W-1:0] min_r;
    logic             err_r;

    // Saturating successor of the open run length.
    always_comb begin
        run_inc = run_len;
        if (run_len != '1) begin
            run_inc = run_len + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rise_r  <= '0;
            fall_r  <= '0;
            max_r   <= '0;
            min_r   <= '1;
            err_r   <= 1'b0;
            q_prev  <= 1'b0;
            run_len <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (mon.Start) begin
                        rise_r <= '0;
                        fall_r <= '0;
                        max_r  <= '0;
                        min_r  <= '1;
                        err_r  <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= ARM;
                    end
                end
                ARM: begin
                    q_prev  <= mon.Q_in;
                    run_len <= RUN_W'(1);
                    state   <= RUN;
                end
                RUN: begin
                    if (mon.Q_in != q_prev) begin
                        if (mon.Q_in) begin
                            if (rise_r != '1) rise_r <= rise_r + 1'b1;
                        end else begin
                            if (fall_r != '1) fall_r <= fall_r + 1'b1;
                        end
                        if (run_len > max_r) max_r <= run_len;
                        if (run_len < min_r) min_r <= run_len;
                        run_len <= RUN_W'(1);
                        q_prev  <= mon.Q_in;
                    end else begin
                        run_len <= run_inc;
                        if (run_inc == LIMIT) err_r <= 1'b1;
                    end
                    // The Stop-cycle sample is folded in above before leaving.
                    if (mon.Stop) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mon.Busy      = busy_r;
    assign mon.Done      = done_r;
    assign mon.Rise_Cnt  = rise_r;
    assign mon.Fall_Cnt  = fall_r;
    assign mon.Max_Run   = max_r;
    assign mon.Min_Run   = min_r;
    assign mon.Err_Stuck = err_r;
endmodule

// File: tb/tb_q_transition_monitor.sv
// Scoreboard bench: two monitor instances (default and narrow/low-limit) share stimulus.
module tb_q_transition_monitor;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic q_in = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;

    always #5 Clk = ~Clk;

    q_transition_monitor_if #(.CNT_W(16), .RUN_W(8)) bd ();
    q_transition_monitor_if #(.CNT_W(4),  .RUN_W(8)) bs ();

    assign bd.Q_in  = q_in;
    assign bd.Start = start;
    assign bd.Stop  = stop;
    assign bs.Q_in  = q_in;
    assign bs.Start = start;
    assign bs.Stop  = stop;

    q_transition_monitor #(.CNT_W(16), .RUN_W(8), .STUCK_LIMIT(200)) u_def (
        .Clk(Clk), .Rst(Rst), .mon(bd)
    );
    q_transition_monitor #(.CNT_W(4), .RUN_W(8), .STUCK_LIMIT(4)) u_small (
        .Clk(Clk), .Rst(Rst), .mon(bs)
    );

    typedef struct {
        int unsigned rise;
        int unsigned fall;
        int unsigned maxr;
        int unsigned minr;
        int unsigned stuck;
    } res_t;

    res_t qd[$];
    res_t qs[$];
    res_t last_d, last_s, ed, es;
    bit   samp[$];
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    task automatic check(string name, int unsigned act, int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp(string tag, int unsigned rise, int unsigned fall, int unsigned maxr,
                       int unsigned minr, int unsigned stuck, res_t e);
        check({tag, " Rise_Cnt"}, rise, e.rise);
        check({tag, " Fall_Cnt"}, fall, e.fall);
        check({tag, " Max_Run"}, maxr, e.maxr);
        check({tag, " Min_Run"}, minr, e.minr);
        check({tag, " Err_Stuck"}, stuck, e.stuck);
    endtask

    // Whole-window reference: samp[0] is the ARM sample, the rest are RUN samples.
    function automatic res_t model(int unsigned cnt_w, int unsigned limit);
        res_t r;
        int unsigned run, len, cmax;
        r.rise = 0; r.fall = 0; r.maxr = 0; r.minr = 255; r.stuck = 0;
        run = 1;
        for (int i = 1; i < samp.size(); i++) begin
            if (samp[i] != samp[i-1]) begin
                if (samp[i]) r.rise++;
                else r.fall++;
                len = (run > 255) ? 255 : run;
                if (len > r.maxr) r.maxr = len;
                if (len < r.minr) r.minr = len;
                run = 1;
            end else begin
                run++;
                if (limit >= 2 && run >= limit) r.stuck = 1;
            end
        end
        cmax = (1 << cnt_w) - 1;
        if (r.rise > cmax) r.rise = cmax;
        if (r.fall > cmax) r.fall = cmax;
        return r;
    endfunction

    always @(negedge Clk) begin
        if (bd.Done) begin
            if (qd.size() == 0) check("def unexpected Done", 1, 0);
            else begin
                ed = qd.pop_front();
                cmp("def", bd.Rise_Cnt, bd.Fall_Cnt, bd.Max_Run, bd.Min_Run, bd.Err_Stuck, ed);
            end
        end
        if (bs.Done) begin
            if (qs.size() == 0) check("small unexpected Done", 1, 0);
            else begin
                es = qs.pop_front();
                cmp("small", bs.Rise_Cnt, bs.Fall_Cnt, bs.Max_Run, bs.Min_Run, bs.Err_Stuck, es);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_vals(string tag);
        check({tag, " def Busy"}, bd.Busy, 0);
        check({tag, " def Done"}, bd.Done, 0);
        check({tag, " def Rise_Cnt"}, bd.Rise_Cnt, 0);
        check({tag, " def Fall_Cnt"}, bd.Fall_Cnt, 0);
        check({tag, " def Max_Run"}, bd.Max_Run, 0);
        check({tag, " def Min_Run"}, bd.Min_Run, 255);
        check({tag, " def Err_Stuck"}, bd.Err_Stuck, 0);
        check({tag, " small Min_Run"}, bs.Min_Run, 255);
        check({tag, " small Err_Stuck"}, bs.Err_Stuck, 0);
    endtask

    // Runs one window over samp; optional Start in RUN, Stop in ARM, Stop alongside Start.
    task automatic window(int unsigned start_mid, bit stop_arm, bit stop_with_start, bit live);
        int unsigned n;
        n = samp.size() - 1;
        start = 1'b1; stop = stop_with_start; tick();
        start = 1'b0; stop = 1'b0;
        check("arm def Busy", bd.Busy, 1);
        check("arm def Rise_Cnt", bd.Rise_Cnt, 0);
        check("arm def Min_Run", bd.Min_Run, 255);
        check("arm def Err_Stuck", bd.Err_Stuck, 0);
        check("arm small Err_Stuck", bs.Err_Stuck, 0);
        check("arm small Max_Run", bs.Max_Run, 0);
        q_in = samp[0]; stop = stop_arm; tick();
        stop = 1'b0;
        last_d = model(16, 200);
        last_s = model(4, 4);
        qd.push_back(last_d);
        qs.push_back(last_s);
        for (int i = 1; i <= int'(n); i++) begin
            q_in  = samp[i];
            stop  = (i == int'(n));
            start = (i == int'(start_mid));
            tick();
            if (live && i <= 6) check("small stuck onset", bs.Err_Stuck, (i >= 3) ? 1 : 0);
            if (i < int'(n)) check("def Busy in RUN", bd.Busy, 1);
        end
        stop = 1'b0; start = 1'b0;
        check("def Done pulse", bd.Done, 1);
        check("small Done pulse", bs.Done, 1);
        q_in = $urandom_range(0, 1);
        tick();
        check("post def Busy", bd.Busy, 0);
        check("post def Done", bd.Done, 0);
        tick();
        tick();
        cmp("hold def", bd.Rise_Cnt, bd.Fall_Cnt, bd.Max_Run, bd.Min_Run, bd.Err_Stuck, last_d);
        cmp("hold small", bs.Rise_Cnt, bs.Fall_Cnt, bs.Max_Run, bs.Min_Run, bs.Err_Stuck, last_s);
    endtask

    initial begin
        Rst = 1'b1;
        tick(); tick();
        reset_vals("reset");
        Rst = 1'b0;
        tick();

        samp = '{0, 0, 0, 1, 1, 0};
        window(0, 0, 0, 0);

        samp.delete();
        for (int i = 0; i < 11; i++) samp.push_back(1'b1);
        window(0, 0, 0, 0);

        samp.delete();
        for (int i = 0; i < 300; i++) samp.push_back(1'b0);
        samp.push_back(1'b1);
        samp.push_back(1'b0);
        window(0, 0, 0, 1);

        samp.delete();
        for (int i = 0; i < 21; i++) samp.push_back(i[0]);
        window(0, 0, 0, 0);
        samp.delete();
        for (int i = 0; i < 41; i++) samp.push_back(~i[0]);
        window(0, 0, 0, 0);

        // Reset in the middle of a window after three transitions.
        start = 1'b1; tick();
        start = 1'b0;
        samp = '{0, 1, 0, 1, 1};
        foreach (samp[i]) begin
            q_in = samp[i];
            tick();
        end
        Rst = 1'b1; tick();
        Rst = 1'b0;
        reset_vals("midreset");
        stop = 1'b1; tick();
        stop = 1'b0;
        check("stop after reset Done", bd.Done, 0);
        tick();
        check("stop after reset Done+1", bd.Done, 0);
        check("stop after reset Busy", bd.Busy, 0);

        samp = '{1, 1, 0, 0, 0, 1, 0, 1, 1};
        window(3, 1, 1, 0);

        for (int w = 0; w < 12; w++) begin
            int unsigned len;
            bit cur;
            samp.delete();
            len = $urandom_range(2, 41);
            cur = $urandom_range(0, 1);
            for (int i = 0; i < int'(len); i++) begin
                if ($urandom_range(0, 2) == 0) cur = ~cur;
                samp.push_back(cur);
            end
            window(($urandom_range(0, 1) == 1) ? $urandom_range(1, len - 2) : 0,
                   $urandom_range(0, 1), $urandom_range(0, 1), 0);
        end

        tick(); tick();
        check("def scoreboard drained", qd.size(), 0);
        check("small scoreboard drained", qs.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
